// File: rtl/lenet_upsample_pkg.sv
// Shared LeNet definitions used by the upsampler.
//   - default stream-interface widths (pixel width, feature-map size)
//   - counter width shared by the frame counters
//   - state encoding of the upsampler FSM
package lenet_upsample_pkg;

  localparam int LENET_WD    = 3;   // default pixel data width
  localparam int LENET_SIZE  = 12;  // default input row length / row count
  localparam int LENET_CNT_W = 8;   // width of col/rep/row counters

  typedef enum logic [2:0] {
    UPS_IDLE    = 3'd0,
    UPS_CAPTURE = 3'd1,
    UPS_GAP     = 3'd2,
    UPS_REPLAY  = 3'd3,
    UPS_DONE    = 3'd4
  } ups_state_t;

endpackage

// File: rtl/lenet_linebuf.sv
// One-row line buffer for the upsampler.
//   clk     : clock
//   wr_en   : write strobe, writes wr_data to wr_addr
//   wr_addr : write address (0..SIZE-1)
//   wr_data : pixel to store
//   rd_en   : read strobe, loads rd_data from rd_addr
//   rd_addr : read address (0..SIZE-1)
//   rd_data : registered read data, holds while rd_en is low
// Contents are deliberately not reset.
module lenet_linebuf #(
  parameter int WD   = 3,
  parameter int SIZE = 12,
  parameter int AW   = 4
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [WD-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [WD-1:0] rd_data
);

  logic [WD-1:0] mem [SIZE];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/lenet_upsample.sv
// Nearest-neighbour 2x upsampler for the LeNet feature-map stream.
// Pass A repeats each incoming pixel twice as it arrives; after a one-cycle
// gap the stored row is replayed (each pixel twice again), giving the
// vertical repeat.
//   i_sclk  : clock
//   i_rstn  : synchronous active-low reset
//   i_vsync : frame start, clears all frame state while high
//   i_hsync : input row window, rising edge marks a row start
//   i_valid : input beat qualifier
//   i_tdata : input pixel
//   o_vsync : i_vsync delayed one cycle
//   o_hsync : output row window
//   o_valid : output beat qualifier
//   o_tdata : output pixel, holds while o_valid is low
//   o_err   : sticky protocol-violation flag
module lenet_upsample
  import lenet_upsample_pkg::*;
#(
  parameter int WD   = LENET_WD,
  parameter int SIZE = LENET_SIZE
) (
  input  logic          i_sclk,
  input  logic          i_rstn,
  input  logic          i_vsync,
  input  logic          i_hsync,
  input  logic          i_valid,
  input  logic [WD-1:0] i_tdata,
  output logic          o_vsync,
  output logic          o_hsync,
  output logic          o_valid,
  output logic [WD-1:0] o_tdata,
  output logic          o_err
);

  localparam int AW = $clog2(SIZE);
  localparam logic [LENET_CNT_W-1:0] SIZE_C   = LENET_CNT_W'(SIZE);
  localparam logic [LENET_CNT_W-1:0] REP_LAST = LENET_CNT_W'(2 * SIZE - 1);

  ups_state_t state_reg, state_next;
  logic [LENET_CNT_W-1:0] col_reg, col_next;
  logic [LENET_CNT_W-1:0] rep_reg, rep_next;
  logic [LENET_CNT_W-1:0] row_reg, row_next;
  logic          dup_reg, dup_next;      // second copy of the last beat pending
  logic          valid_reg, valid_next;
  logic          hsync_reg, hsync_next;
  logic          err_reg, err_next;
  logic          src_lb_reg, src_lb_next; // o_tdata source: 1 = line buffer
  logic [WD-1:0] cap_data_reg, cap_data_next;
  logic          vsync_reg;
  logic          prev_valid_reg;
  logic          prev_hsync_reg;

  logic                   wr_en, rd_en;
  logic [AW-1:0]          wr_addr, rd_addr;
  logic [WD-1:0]          rd_data;
  logic                   too_fast, hs_rise, restart;
  logic [LENET_CNT_W-1:0] base, rep_inc, row_inc;

  lenet_linebuf #(
    .WD   (WD),
    .SIZE (SIZE),
    .AW   (AW)
  ) u_linebuf (
    .clk     (i_sclk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (i_tdata),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always_comb begin
    state_next    = state_reg;
    col_next      = col_reg;
    rep_next      = rep_reg;
    row_next      = row_reg;
    dup_next      = 1'b0;
    valid_next    = 1'b0;
    hsync_next    = hsync_reg;
    err_next      = err_reg;
    src_lb_next   = src_lb_reg;
    cap_data_next = cap_data_reg;
    wr_en         = 1'b0;
    wr_addr       = '0;
    rd_en         = 1'b0;
    rd_addr       = '0;
    too_fast      = i_valid && prev_valid_reg;
    hs_rise       = i_hsync && !prev_hsync_reg;
    restart       = 1'b0;
    base          = col_reg;
    rep_inc       = rep_reg + 1'b1;
    row_inc       = row_reg + 1'b1;

    case (state_reg)
      UPS_IDLE: begin
        if (i_valid && too_fast) begin
          err_next = 1'b1;
        end else if (i_valid) begin
          wr_en         = 1'b1;
          cap_data_next = i_tdata;
          src_lb_next   = 1'b0;
          valid_next    = 1'b1;
          hsync_next    = 1'b1;
          dup_next      = 1'b1;
          col_next      = 8'd1;
          state_next    = UPS_CAPTURE;
        end
      end

      UPS_CAPTURE: begin
        // A new row start before the row filled: flag it and begin again at col 0.
        restart = hs_rise && (col_reg != '0);
        if (restart) begin
          err_next = 1'b1;
          base     = '0;
          col_next = '0;
        end
        if (i_valid && !too_fast && (base < SIZE_C)) begin
          wr_en         = 1'b1;
          wr_addr       = base[AW-1:0];
          cap_data_next = i_tdata;
          src_lb_next   = 1'b0;
          valid_next    = 1'b1;
          dup_next      = 1'b1;
          col_next      = base + 1'b1;
        end else begin
          if (i_valid) err_next = 1'b1;
          if (dup_reg) begin
            valid_next = 1'b1;
          end else if (base == SIZE_C) begin
            // Row full and its last pair already out: one idle cycle follows.
            hsync_next = 1'b0;
            state_next = UPS_GAP;
          end
        end
      end

      UPS_GAP: begin
        if (i_valid) err_next = 1'b1;
        rd_en       = 1'b1;
        rd_addr     = '0;
        src_lb_next = 1'b1;
        valid_next  = 1'b1;
        hsync_next  = 1'b1;
        rep_next    = '0;
        state_next  = UPS_REPLAY;
      end

      UPS_REPLAY: begin
        if (i_valid) err_next = 1'b1;
        if (rep_reg != REP_LAST) begin
          // Fetch the pixel for the next output slot.
          rd_en      = 1'b1;
          rd_addr    = rep_inc[AW:1];
          valid_next = 1'b1;
          rep_next   = rep_inc;
        end else begin
          hsync_next = 1'b0;
          col_next   = '0;
          row_next   = row_inc;
          state_next = (row_inc == SIZE_C) ? UPS_DONE : UPS_IDLE;
        end
      end

      UPS_DONE: begin
        if (i_valid) err_next = 1'b1;
      end

      default: state_next = UPS_IDLE;
    endcase

    if (i_vsync) begin
      state_next    = UPS_IDLE;
      col_next      = '0;
      rep_next      = '0;
      row_next      = '0;
      dup_next      = 1'b0;
      valid_next    = 1'b0;
      hsync_next    = 1'b0;
      err_next      = 1'b0;
      src_lb_next   = src_lb_reg;
      cap_data_next = cap_data_reg;
      wr_en         = 1'b0;
      rd_en         = 1'b0;
    end
  end

  always_ff @(posedge i_sclk) begin
    if (!i_rstn) begin
      state_reg      <= UPS_IDLE;
      col_reg        <= '0;
      rep_reg        <= '0;
      row_reg        <= '0;
      dup_reg        <= 1'b0;
      valid_reg      <= 1'b0;
      hsync_reg      <= 1'b0;
      err_reg        <= 1'b0;
      src_lb_reg     <= 1'b0;
      cap_data_reg   <= '0;
      vsync_reg      <= 1'b0;
      prev_valid_reg <= 1'b0;
      prev_hsync_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      col_reg        <= col_next;
      rep_reg        <= rep_next;
      row_reg        <= row_next;
      dup_reg        <= dup_next;
      valid_reg      <= valid_next;
      hsync_reg      <= hsync_next;
      err_reg        <= err_next;
      src_lb_reg     <= src_lb_next;
      cap_data_reg   <= cap_data_next;
      vsync_reg      <= i_vsync;
      prev_valid_reg <= i_valid;
      prev_hsync_reg <= i_hsync;
    end
  end

  // Both data sources are registers and the select is registered, so o_tdata
  // carries no combinational path from the inputs.
  assign o_tdata = src_lb_reg ? rd_data : cap_data_reg;
  assign o_vsync = vsync_reg;
  assign o_hsync = hsync_reg;
  assign o_valid = valid_reg;
  assign o_err   = err_reg;

endmodule

// File: tb/tb_lenet_upsample.sv
module tb_lenet_upsample;
  import lenet_upsample_pkg::*;

  localparam int WD   = 3;
  localparam int SIZE = 4;

  logic          i_sclk = 1'b0;
  logic          i_rstn;
  logic          i_vsync;
  logic          i_hsync;
  logic          i_valid;
  logic [WD-1:0] i_tdata;
  logic          o_vsync;
  logic          o_hsync;
  logic          o_valid;
  logic [WD-1:0] o_tdata;
  logic          o_err;

  int checks     = 0;
  int errors     = 0;
  int out_count  = 0;
  int hs_windows = 0;
  logic hs_prev  = 1'b0;
  logic [WD-1:0] exp_q [$];

  lenet_upsample #(.WD(WD), .SIZE(SIZE)) dut (
    .i_sclk  (i_sclk),
    .i_rstn  (i_rstn),
    .i_vsync (i_vsync),
    .i_hsync (i_hsync),
    .i_valid (i_valid),
    .i_tdata (i_tdata),
    .o_vsync (o_vsync),
    .o_hsync (o_hsync),
    .o_valid (o_valid),
    .o_tdata (o_tdata),
    .o_err   (o_err)
  );

  always #5 i_sclk = ~i_sclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Move to just after the next rising edge.
  task automatic tick();
    @(posedge i_sclk);
    #1;
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a beat.
  always @(negedge i_sclk) begin
    logic [WD-1:0] e;
    if (i_rstn && o_hsync && !hs_prev) hs_windows++;
    hs_prev = o_hsync;
    if (o_valid) begin
      out_count++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %0d expected none at %0t", o_tdata, $time);
      end else begin
        e = exp_q.pop_front();
        $display("out beat data=%0d exp=%0d hsync=%0b t=%0t", o_tdata, e, o_hsync, $time);
        chk("out_data", 32'(o_tdata), 32'(e));
        chk("out_hsync", 32'(o_hsync), 32'd1);
      end
    end
  end

  task automatic vsync_pulse();
    i_vsync = 1'b1;
    tick();
    i_vsync = 1'b0;
    @(negedge i_sclk);
    chk("vsync_delay", 32'(o_vsync), 32'd1);
    chk("vsync_valid", 32'(o_valid), 32'd0);
    chk("vsync_hsync", 32'(o_hsync), 32'd0);
    chk("vsync_err", 32'(o_err), 32'd0);
    tick();
    chk("vsync_fall", 32'(o_vsync), 32'd0);
    repeat (2) tick();
  endtask

  task automatic beat(input logic [WD-1:0] v);
    i_valid = 1'b1;
    i_tdata = v;
    exp_q.push_back(v);
    exp_q.push_back(v);
    $display("in  beat data=%0d t=%0t", v, $time);
    tick();
    i_valid = 1'b0;
  endtask

  // Sends one row of four pixels (pix[2:0] first) at the given spacing and
  // queues n_replay replay outputs. With timing=1 it also checks the gap
  // cycle and the exact end of the replay window.
  task automatic send_row(input logic [4*WD-1:0] pix, input int spacing,
                          input int n_replay, input bit timing);
    i_hsync = 1'b1;
    for (int i = 0; i < SIZE; i++) begin
      beat(pix[i*WD +: WD]);
      if (i < SIZE - 1) repeat (spacing - 1) tick();
    end
    i_hsync = 1'b0;
    for (int k = 0; k < n_replay; k++) exp_q.push_back(pix[(k >> 1)*WD +: WD]);
    if (timing) begin
      tick();
      @(negedge i_sclk);
      chk("passA_hsync_tail", 32'(o_hsync), 32'd1);
      tick();
      @(negedge i_sclk);
      chk("gap_hsync", 32'(o_hsync), 32'd0);
      chk("gap_valid", 32'(o_valid), 32'd0);
      tick();
      @(negedge i_sclk);
      chk("replay_start_valid", 32'(o_valid), 32'd1);
      repeat (2 * SIZE) tick();
      @(negedge i_sclk);
      chk("replay_end_valid", 32'(o_valid), 32'd0);
      chk("replay_end_hsync", 32'(o_hsync), 32'd0);
    end
  endtask

  initial begin
    int w0, o0;
    i_rstn  = 1'b0;
    i_vsync = 1'b0;
    i_hsync = 1'b0;
    i_valid = 1'b0;
    i_tdata = '0;

    // 1: reset, then idle
    tick();
    @(negedge i_sclk);
    chk("rst_vsync", 32'(o_vsync), 32'd0);
    chk("rst_hsync", 32'(o_hsync), 32'd0);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_tdata", 32'(o_tdata), 32'd0);
    chk("rst_err", 32'(o_err), 32'd0);
    repeat (2) tick();
    i_rstn = 1'b1;
    for (int c = 0; c < 50; c++) begin
      tick();
      @(negedge i_sclk);
      chk("idle_err", 32'(o_err), 32'd0);
      chk("idle_valid", 32'(o_valid), 32'd0);
    end

    // 2: single row, spacing 2, exact timing
    vsync_pulse();
    send_row({3'd4, 3'd3, 3'd2, 3'd1}, 2, 8, 1'b1);
    repeat (6) tick();

    // 3: full frame, then a beat in DONE
    vsync_pulse();
    w0 = hs_windows;
    o0 = out_count;
    send_row({3'd4, 3'd3, 3'd2, 3'd1}, 2, 8, 1'b0);
    repeat (14) tick();
    send_row({3'd0, 3'd7, 3'd6, 3'd5}, 3, 8, 1'b0);
    repeat (14) tick();
    send_row({3'd2, 3'd4, 3'd6, 3'd1}, 2, 8, 1'b0);
    repeat (14) tick();
    send_row({3'd3, 3'd3, 3'd5, 3'd7}, 4, 8, 1'b0);
    repeat (14) tick();
    chk("frame_outputs", 32'(out_count - o0), 32'd64);
    chk("frame_hsync_windows", 32'(hs_windows - w0), 32'd8);
    chk("frame_state_done", 32'(dut.state_reg), 32'(UPS_DONE));
    chk("done_err_before", 32'(o_err), 32'd0);
    i_valid = 1'b1;
    i_tdata = 3'd5;
    tick();
    i_valid = 1'b0;
    @(negedge i_sclk);
    chk("done_beat_err", 32'(o_err), 32'd1);
    repeat (6) tick();

    // 4: two consecutive beats in CAPTURE
    vsync_pulse();
    i_hsync = 1'b1;
    beat(3'd1);
    tick();
    beat(3'd2);
    i_valid = 1'b1;
    i_tdata = 3'd6;
    @(negedge i_sclk);
    chk("fast_err_before", 32'(o_err), 32'd0);
    tick();
    i_valid = 1'b0;
    @(negedge i_sclk);
    chk("fast_err", 32'(o_err), 32'd1);
    tick();
    beat(3'd3);
    tick();
    beat(3'd4);
    i_hsync = 1'b0;
    for (int k = 0; k < 2 * SIZE; k++) exp_q.push_back(WD'((k >> 1) + 1));
    repeat (14) tick();

    // 5: vsync mid-replay, then scenario 2 again
    vsync_pulse();
    send_row({3'd4, 3'd3, 3'd2, 3'd1}, 2, 3, 1'b0);
    repeat (4) tick();
    i_valid = 1'b1;
    i_tdata = 3'd5;
    tick();
    i_valid = 1'b0;
    @(negedge i_sclk);
    chk("replay_beat_err", 32'(o_err), 32'd1);
    vsync_pulse();
    send_row({3'd4, 3'd3, 3'd2, 3'd1}, 2, 8, 1'b1);
    repeat (6) tick();

    // 6: partial row restart
    vsync_pulse();
    i_hsync = 1'b1;
    beat(3'd7);
    tick();
    beat(3'd6);
    i_hsync = 1'b0;
    tick();
    i_hsync = 1'b1;
    beat(3'd1);
    @(negedge i_sclk);
    chk("partial_err", 32'(o_err), 32'd1);
    tick();
    beat(3'd2);
    tick();
    beat(3'd3);
    tick();
    beat(3'd4);
    i_hsync = 1'b0;
    for (int k = 0; k < 2 * SIZE; k++) exp_q.push_back(WD'((k >> 1) + 1));

    // drain
    for (int c = 0; c < 100 && exp_q.size() != 0; c++) tick();
    repeat (4) tick();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lenet_upsample.md
# lenet_upsample

Nearest-neighbour 2x upsampler (unpooling) for the LeNet feature-map stream. It consumes a SIZE x SIZE raster on the vsync/hsync/valid/tdata stream interface and emits a 2SIZE x 2SIZE raster on the same interface. Each input pixel is repeated horizontally, and each row is repeated vertically from a one-row line buffer. It is the inverse-direction counterpart of the pooling stage and sits between a pooled feature map and any stage that needs it back at pre-pool resolution.

## Interface
- WD, 3, pixel data width.
- SIZE, 12, input row length and row count (output is 2*SIZE). Legal range 2..127.
- i_sclk  in  1  clock.
- i_rstn  in  1  synchronous active-low reset.
- i_vsync  in  1  frame start. While high, all frame state is cleared.
- i_hsync  in  1  input row window. Its rising edge marks a row start.
- i_valid  in  1  qualifies i_tdata beat.
- i_tdata  in  WD  input pixel.
- o_vsync  out  1  i_vsync delayed 1 cycle.
- o_hsync  out  1  output row window.
- o_valid  out  1  qualifies o_tdata.
- o_tdata  out  WD  output pixel.
- o_err  out  1  sticky protocol-violation flag.

## Operation
- States: IDLE, CAPTURE, GAP, REPLAY, DONE. Counters: col (0..SIZE-1), rep (0..2*SIZE-1), row (0..SIZE); each is 8 bits wide.
- IDLE: an i_valid beat is written to linebuf[0], col is set to 1, and the state goes to CAPTURE. The beat is emitted on the next two cycles.
- CAPTURE: each i_valid beat is written to linebuf[col] and emitted twice, then col increments. When the SIZE-th beat is accepted, the state goes to GAP after that beat's second output.
- GAP: lasts exactly 1 cycle, with o_hsync=0 and o_valid=0. The state then goes to REPLAY with rep=0.
- REPLAY: emits linebuf[rep>>1] for 2*SIZE consecutive cycles, with o_valid=1 on every cycle. At the end, row increments. If row reaches SIZE the state goes to DONE, otherwise to IDLE.
- DONE: holds until i_vsync.
- Input rate rule: i_valid is never high on two consecutive cycles. Any i_valid in GAP, REPLAY or DONE is a violation.
  - Every violation sets o_err and the offending beat is dropped, with no write and no output.
  - Upstream guarantees a gap of at least 2*SIZE+2 cycles between the last beat of one row and the first beat of the next.
- Partial row: an i_hsync rising edge in CAPTURE with col≠0 sets o_err. The row restarts, with that cycle's beat (if valid) taken as col 0. Rows already replayed are kept.
- i_vsync in any state:
  - forces IDLE and clears col, rep, row and o_err;
  - drives o_valid=0 and o_hsync=0 from the next cycle.
  - If i_vsync and i_valid are high together, i_vsync wins and the beat is dropped.
- Reset (i_rstn=0) has the same effect as i_vsync and also clears o_vsync. The line buffer contents are not reset.
- Data is passed through without arithmetic. o_tdata holds its last value while o_valid=0.

## Timing
- Reset values: o_vsync=0, o_hsync=0, o_valid=0, o_tdata=0, o_err=0.
- Capture latency: a beat accepted at cycle t gives o_valid=1 with o_tdata=beat at t+1 and t+2.
  - With beat spacing of 2, pass A output is gapless.
  - With larger spacing, o_valid drops between pairs and o_hsync stays high.
- o_hsync (pass A): rises at first-beat+1 and stays high through last-beat+2.
- With the last beat at cycle t:
  - GAP is at t+3.
  - REPLAY outputs occupy t+4 .. t+3+2*SIZE, with o_hsync high for exactly those cycles.
- o_err rises the cycle after the violating input.
- o_vsync equals i_vsync registered.
- All outputs are registered. Line buffer reads go into the o_tdata register with 1-cycle latency. The read for rep=0 is issued in GAP.

## Structure
- Shared LeNet package holds:
  - state encoding constants (UPS_IDLE, UPS_CAPTURE, UPS_GAP, UPS_REPLAY, UPS_DONE);
  - the common stream-interface width parameter defaults.
- One sub-module, lenet_linebuf: a SIZE x WD single-write, single-read register array with synchronous write and registered read.
- The FSM, counters and output registers live in the top.

## Test plan
Bench uses WD=3, SIZE=4.
1. Reset held 3 cycles, then released with no input -> all outputs stay 0, and o_err stays 0 for 50 cycles.
2. vsync pulse, then one row of 1,2,3,4 at 2-cycle spacing, first beat at cycle t -> o_tdata 1,1,2,2,3,3,4,4 on t+1..t+8 (o_hsync high), o_hsync=0 at t+9, then 1,1,2,2,3,3,4,4 on t+10..t+17 with o_hsync high.
3. Full 4x4 frame with legal row gaps -> 64 valid outputs, 8 o_hsync windows, state DONE. A further beat of value 5 then sets o_err=1 and produces no output.
4. Two consecutive-cycle i_valid beats in CAPTURE -> o_err=1 one cycle after the second, which is dropped. The row completes on the next legal beats.
5. i_vsync asserted mid-REPLAY -> o_valid=0 and o_hsync=0 the next cycle, and o_err cleared. A following legal row reproduces scenario 2 exactly.
6. i_hsync rising edge after 2 beats (7,6), then 4 beats 1,2,3,4 -> o_err=1, and the replay pass emits 1,1,2,2,3,3,4,4.
